// File: rtl/bb_pkg.sv
// Shared constants for the ball controller: screen and paddle geometry,
// the lives preset and the 2-bit controller state encoding.
package bb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] X_MAX    = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX    = 7'(SCREEN_H - 1);
    localparam logic [6:0] PADDLE_Y = 7'd116;
    localparam logic [8:0] PADDLE_W = 9'd20;
    localparam logic [1:0] LIVES    = 2'd3;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LOST      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    // Widened to 9 bits so a paddle near the right edge never wraps to column 0.
    function automatic logic on_paddle(input logic [7:0] x, input logic [7:0] paddle_x);
        logic [8:0] left;
        logic [8:0] right;
        left  = {1'b0, paddle_x};
        right = left + PADDLE_W - 9'd1;
        return ({1'b0, x} >= left) && ({1'b0, x} <= right);
    endfunction

endpackage

// File: rtl/ball_dir_ctrl_if.sv
// Signal bundle between the game environment (paddle, bricks, ball position
// block) and the ball direction controller.
interface ball_dir_ctrl_if;

    logic       tick;
    logic       launch;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] paddle_x;
    logic       brick_hit;
    logic       move_en;
    logic       ball_rst_n;
    logic       x_du;
    logic       y_du;
    logic       bounce;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output tick, launch, x, y, paddle_x, brick_hit,
        input  move_en, ball_rst_n, x_du, y_du, bounce, lives, game_over
    );

    modport slave (
        input  tick, launch, x, y, paddle_x, brick_hit,
        output move_en, ball_rst_n, x_du, y_du, bounce, lives, game_over
    );

endinterface

// File: rtl/ball_bounce_check.sv
// Combinational edge detector: decides whether the ball must reflect on
// either axis, or has reached the floor, given its position and heading.
module ball_bounce_check
    import bb_pkg::*;
(
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       x_du,
    input  logic       y_du,
    input  logic [7:0] paddle_x,
    output logic       flip_x,
    output logic       flip_y,
    output logic       miss
);

    assign flip_x = (x_du && (x == X_MAX)) || (!x_du && (x == 8'd0));

    assign flip_y = (!y_du && (y == 7'd0)) ||
                    (y_du && (y == PADDLE_Y - 7'd1) && on_paddle(x, paddle_x));

    assign miss = y_du && (y == Y_MAX);

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction and rules controller: serve / play / lost / game-over FSM,
// direction registers, bounce pulse and lives counter.
module ball_dir_ctrl
    import bb_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    ball_dir_ctrl_if.slave  bus
);

    state_e     state_q, state_d;
    logic       x_du_q, x_du_d;
    logic       y_du_q, y_du_d;
    logic       bounce_q, bounce_d;
    logic [1:0] lives_q, lives_d;
    logic       ball_rst_n_q;
    logic       game_over_q;

    logic flip_x, flip_y, miss;
    logic y_flip;

    ball_bounce_check u_check (
        .x        (bus.x),
        .y        (bus.y),
        .x_du     (x_du_q),
        .y_du     (y_du_q),
        .paddle_x (bus.paddle_x),
        .flip_x   (flip_x),
        .flip_y   (flip_y),
        .miss     (miss)
    );

    // A brick hit coinciding with a wall/paddle hit must still flip y only once.
    assign y_flip = flip_y | bus.brick_hit;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        x_du_d   = x_du_q;
        y_du_d   = y_du_q;
        lives_d  = lives_q;
        bounce_d = 1'b0;
        unique case (state_q)
            ST_SERVE: begin
                x_du_d = 1'b1;
                y_du_d = 1'b0;
                if (bus.launch) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (miss) begin
                    state_d = ST_LOST;
                end else begin
                    x_du_d   = x_du_q ^ flip_x;
                    y_du_d   = y_du_q ^ y_flip;
                    bounce_d = flip_x | y_flip;
                end
            end
            ST_LOST: begin
                lives_d = lives_q - 2'd1;
                state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_SERVE;
                x_du_d  = 1'b1;
                y_du_d  = 1'b0;
            end
            ST_GAME_OVER: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_SERVE;
            x_du_q       <= 1'b1;
            y_du_q       <= 1'b0;
            bounce_q     <= 1'b0;
            lives_q      <= LIVES;
            ball_rst_n_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_du_q       <= x_du_d;
            y_du_q       <= y_du_d;
            bounce_q     <= bounce_d;
            lives_q      <= lives_d;
            ball_rst_n_q <= (state_d == ST_PLAY);
            game_over_q  <= (state_d == ST_GAME_OVER);
        end
    end

    assign bus.move_en    = bus.tick && (state_q == ST_PLAY);
    assign bus.ball_rst_n = ball_rst_n_q;
    assign bus.x_du       = x_du_q;
    assign bus.y_du       = y_du_q;
    assign bus.bounce     = bounce_q;
    assign bus.lives      = lives_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Randomised scoreboard bench for ball_dir_ctrl: a game-level model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_ball_dir_ctrl;

    localparam int W        = 160;
    localparam int H        = 120;
    localparam int PAD_TOP  = 116;
    localparam int PAD_W    = 20;
    localparam int N_CYCLES = 3000;

    typedef enum int {MD_SERVE, MD_PLAY, MD_LOST, MD_OVER} mode_e;

    typedef struct {
        int move_en;
        int ball_rst_n;
        int x_du;
        int y_du;
        int bounce;
        int lives;
        int game_over;
        bit chk_dir;
    } exp_t;

    logic clk;
    logic resetn;
    ball_dir_ctrl_if bus ();

    ball_dir_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests_run = 0;
    int   fail_cnt  = 0;
    exp_t exp_q[$];

    // Game-level model: headings as +1/-1 steps, lives as a plain count.
    mode_e m_mode;
    int    m_dx, m_dy, m_lives, m_bounce;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MD_SERVE;
        m_dx     = 1;
        m_dy     = -1;
        m_lives  = 3;
        m_bounce = 0;
    endtask

    task automatic model_step(input int launch, input int x, input int y,
                              input int px, input int brick);
        bit hx, hy;
        m_bounce = 0;
        case (m_mode)
            MD_SERVE: begin
                m_dx = 1;
                m_dy = -1;
                if (launch != 0) m_mode = MD_PLAY;
            end
            MD_PLAY: begin
                if (m_dy > 0 && y == H - 1) begin
                    m_mode = MD_LOST;
                end else begin
                    hx = (m_dx > 0 && x == W - 1) || (m_dx < 0 && x == 0);
                    hy = (m_dy < 0 && y == 0) ||
                         (m_dy > 0 && y + 1 == PAD_TOP && x >= px && x <= px + PAD_W - 1);
                    if (brick != 0) hy = 1'b1;
                    if (hx) m_dx = -m_dx;
                    if (hy) m_dy = -m_dy;
                    m_bounce = (hx || hy) ? 1 : 0;
                end
            end
            MD_LOST: begin
                m_lives = m_lives - 1;
                m_mode  = (m_lives == 0) ? MD_OVER : MD_SERVE;
                m_dx    = 1;
                m_dy    = -1;
            end
            default: ;
        endcase
    endtask

    task automatic push_expect(input int tick);
        exp_t e;
        e.move_en    = (tick != 0 && m_mode == MD_PLAY) ? 1 : 0;
        e.ball_rst_n = (m_mode == MD_PLAY) ? 1 : 0;
        e.x_du       = (m_dx > 0) ? 1 : 0;
        e.y_du       = (m_dy > 0) ? 1 : 0;
        e.bounce     = m_bounce;
        e.lives      = m_lives;
        e.game_over  = (m_mode == MD_OVER) ? 1 : 0;
        e.chk_dir    = (m_mode == MD_SERVE || m_mode == MD_PLAY);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("move_en",    int'(bus.move_en),    e.move_en);
            check("ball_rst_n", int'(bus.ball_rst_n), e.ball_rst_n);
            check("bounce",     int'(bus.bounce),     e.bounce);
            check("lives",      int'(bus.lives),      e.lives);
            check("game_over",  int'(bus.game_over),  e.game_over);
            if (e.chk_dir) begin
                check("x_du", int'(bus.x_du), e.x_du);
                check("y_du", int'(bus.y_du), e.y_du);
            end
        end
    end

    initial begin
        int px, xv, yv, r, tick, prev_tick, launch, brick;
        resetn        = 1'b0;
        bus.tick      = 1'b0;
        bus.launch    = 1'b0;
        bus.x         = 8'd0;
        bus.y         = 7'd0;
        bus.paddle_x  = 8'd0;
        bus.brick_hit = 1'b0;
        prev_tick     = 0;
        model_reset();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            px = ($urandom_range(0, 6) == 0) ? 250 : int'($urandom_range(0, W - 1));
            r  = int'($urandom_range(0, 9));
            case (r)
                0: xv = 0;
                1: xv = W - 1;
                2: xv = px;
                3: xv = (px + PAD_W - 1) % 256;
                4: xv = (px + PAD_W) % 256;
                5: xv = 255;
                default: xv = int'($urandom_range(0, W - 1));
            endcase
            r = int'($urandom_range(0, 19));
            case (r)
                0, 1: yv = 0;
                2, 3: yv = PAD_TOP - 1;
                4:    yv = H - 1;
                default: yv = int'($urandom_range(1, H - 2));
            endcase
            tick      = (prev_tick == 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
            prev_tick = tick;
            launch    = ($urandom_range(0, 3) == 0) ? 1 : 0;
            brick     = ($urandom_range(0, 9) == 0) ? 1 : 0;

            resetn        = ((cyc % 500) < 2) ? 1'b0 : 1'b1;
            bus.tick      = 1'(tick);
            bus.launch    = 1'(launch);
            bus.x         = 8'(xv);
            bus.y         = 7'(yv);
            bus.paddle_x  = 8'(px);
            bus.brick_hit = 1'(brick);

            if (!resetn) model_reset();
            push_expect(tick);
            if (resetn) model_step(launch, xv, yv, px, brick);
        end

        bus.tick = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
